// File: rtl/shared_mem_banked_if.sv
// Port bundle for the banked shared scratchpad: per-port request/grant
// handshake, write payload and registered read response.
interface shared_mem_banked_if #(
   parameter int PORT_COUNT = 4,
   parameter int ADDR_SIZE  = 24,
   parameter int BUS_SIZE   = 160
);
   logic [PORT_COUNT-1:0]                req;
   logic [PORT_COUNT-1:0]                we;
   logic [PORT_COUNT-1:0][ADDR_SIZE-1:0] addr;
   logic [PORT_COUNT-1:0][BUS_SIZE-1:0]  wdata;
   logic [PORT_COUNT-1:0][2:0]           wsize;
   logic [PORT_COUNT-1:0]                gnt;
   logic [PORT_COUNT-1:0]                rvalid;
   logic [PORT_COUNT-1:0][BUS_SIZE-1:0]  rdata;

   modport master (
      output req, we, addr, wdata, wsize,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, wsize,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/shared_mem_banked.sv
// Multi-bank shared scratchpad. Blocks are low-order interleaved across
// NUM_BANKS banks; each bank owns a round-robin arbiter so independent banks
// can serve different ports in the same cycle. Reads return one cycle after
// their grant; writes may cover a prefix of the block's units.
module shared_mem_banked #(
   parameter int PORT_COUNT = 4,
   parameter int NUM_BANKS  = 2,
   parameter int BUS_SIZE   = 160,
   parameter int UNIT_SIZE  = 32,
   parameter int MEM_SIZE   = 1024,
   parameter int ADDR_SIZE  = 24
) (
   input logic               i_clk,
   input logic               i_rst,
   shared_mem_banked_if.slave bus
);
   localparam int BLOCK_UNITS = BUS_SIZE / UNIT_SIZE;
   localparam int ROWS        = MEM_SIZE / NUM_BANKS;
   localparam int PW          = $clog2(PORT_COUNT);
   localparam int BW          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1;

   generate
      if (BUS_SIZE % UNIT_SIZE != 0) begin : g_bad_unit_width
         $error("shared_mem_banked: BUS_SIZE must be a multiple of UNIT_SIZE");
      end
      if (PORT_COUNT < 2) begin : g_bad_port_count
         $error("shared_mem_banked: PORT_COUNT must be at least 2");
      end
      if (MEM_SIZE % NUM_BANKS != 0) begin : g_bad_mem_size
         $error("shared_mem_banked: MEM_SIZE must be a multiple of NUM_BANKS");
      end
   endgenerate

   logic [BW-1:0]                       port_bank [PORT_COUNT];
   logic [RW-1:0]                       port_row  [PORT_COUNT];
   logic [PW-1:0]                       rr        [NUM_BANKS];
   logic [PW-1:0]                       win       [NUM_BANKS];
   logic [NUM_BANKS-1:0]                bank_hit;
   logic [PORT_COUNT-1:0]               gnt;
   logic [BLOCK_UNITS-1:0]              unit_en   [NUM_BANKS];
   logic [BUS_SIZE-1:0]                 mem       [NUM_BANKS][ROWS];
   logic [PORT_COUNT-1:0]               rvalid_q;
   logic [PORT_COUNT-1:0][BUS_SIZE-1:0] rdata_q;

   // Split each port's block address into bank (low bits) and row; high bits wrap.
   always_comb begin
      for (int p = 0; p < PORT_COUNT; p++) begin
         port_bank[p] = BW'(bus.addr[p] % NUM_BANKS);
         port_row[p]  = RW'((bus.addr[p] / NUM_BANKS) % ROWS);
      end
   end

   // Per-bank round-robin search starting at rr[b]; nothing is granted during reset.
   always_comb begin
      int cand;
      cand     = 0;
      gnt      = '0;
      bank_hit = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         win[b] = '0;
         for (int i = 0; i < PORT_COUNT; i++) begin
            cand = (int'(rr[b]) + i) % PORT_COUNT;
            if (!bank_hit[b] && bus.req[PW'(cand)] &&
                int'(port_bank[PW'(cand)]) == b) begin
               bank_hit[b]      = 1'b1;
               win[b]           = PW'(cand);
               gnt[PW'(cand)]   = 1'b1;
            end
         end
      end
      if (i_rst) begin
         gnt      = '0;
         bank_hit = '0;
      end
   end

   // Advance each bank's pointer past the port it just served; idle banks hold.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            rr[b] <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_hit[b]) begin
               rr[b] <= (int'(win[b]) == PORT_COUNT - 1) ? '0 : win[b] + PW'(1);
            end
         end
      end
   end

   // Unit mask for each bank's winning writer: wsize 0 or oversize means the whole block.
   always_comb begin
      int n;
      n = 0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         n = int'(bus.wsize[win[b]]);
         for (int k = 0; k < BLOCK_UNITS; k++) begin
            unit_en[b][k] = (n == 0 || n > BLOCK_UNITS) ? 1'b1 : (k < n);
         end
      end
   end

   // Storage is deliberately not reset; only the enabled units of a granted write change.
   always_ff @(posedge i_clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank_hit[b] && bus.we[win[b]]) begin
            for (int k = 0; k < BLOCK_UNITS; k++) begin
               if (unit_en[b][k]) begin
                  mem[b][port_row[win[b]]][k*UNIT_SIZE +: UNIT_SIZE] <=
                     bus.wdata[win[b]][k*UNIT_SIZE +: UNIT_SIZE];
               end
            end
         end
      end
   end

   // Capture read data at the grant edge; rvalid pulses for one cycle, rdata holds otherwise.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         for (int p = 0; p < PORT_COUNT; p++) begin
            rvalid_q[p] <= gnt[p] & ~bus.we[p];
            if (gnt[p] && !bus.we[p]) begin
               rdata_q[p] <= mem[port_bank[p]][port_row[p]];
            end
         end
      end
   end

   assign bus.gnt    = gnt;
   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_shared_mem_banked.sv
// Testbench for shared_mem_banked: directed scenarios followed by random
// multi-port traffic, all checked against a flat-memory reference model.
module tb_shared_mem_banked;
   localparam int PC = 4;
   localparam int NB = 2;
   localparam int BS = 160;
   localparam int US = 32;
   localparam int MS = 1024;
   localparam int AS = 24;
   localparam int BU = BS / US;

   logic clk = 1'b0;
   logic rst;

   // Free-running clock.
   always #5 clk = ~clk;

   shared_mem_banked_if #(.PORT_COUNT(PC), .ADDR_SIZE(AS), .BUS_SIZE(BS)) bus ();

   shared_mem_banked #(
      .PORT_COUNT(PC), .NUM_BANKS(NB), .BUS_SIZE(BS),
      .UNIT_SIZE(US), .MEM_SIZE(MS), .ADDR_SIZE(AS)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   logic [BS-1:0] ref_mem [MS];
   int            rr_m    [NB];
   int            win_m   [NB];
   logic [PC-1:0] exp_gnt;
   logic [PC-1:0] exp_rvalid;
   logic [BS-1:0] exp_rdata [PC];
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic checkOutput(input string tag, input logic [BS-1:0] got, input logic [BS-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input int p, input logic req, input logic we,
                                input logic [AS-1:0] addr, input logic [BS-1:0] data,
                                input logic [2:0] wsize);
      bus.req[p]   = req;
      bus.we[p]    = we;
      bus.addr[p]  = addr;
      bus.wdata[p] = data;
      bus.wsize[p] = wsize;
   endtask

   task automatic idle_all();
      for (int p = 0; p < PC; p++) applyStimulus(p, 1'b0, 1'b0, '0, '0, 3'd0);
   endtask

   function automatic logic [BS-1:0] rand_block();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Winner per bank = requester at the smallest cyclic distance from that bank's pointer.
   task automatic model_arbitrate();
      int d;
      int best_d;
      exp_gnt = '0;
      for (int b = 0; b < NB; b++) begin
         win_m[b] = -1;
         best_d   = PC;
         for (int p = 0; p < PC; p++) begin
            if (bus.req[p] && int'(bus.addr[p] % NB) == b) begin
               d = (p - rr_m[b] + PC) % PC;
               if (d < best_d) begin
                  best_d   = d;
                  win_m[b] = p;
               end
            end
         end
         if (rst) win_m[b] = -1;
         if (win_m[b] >= 0) exp_gnt[win_m[b]] = 1'b1;
      end
   endtask

   // Effect of one clock edge on the flat memory, read responses and pointers.
   task automatic model_clock();
      int idx;
      int n;
      exp_rvalid = '0;
      for (int p = 0; p < PC; p++) begin
         if (exp_gnt[p] && !bus.we[p]) begin
            idx           = int'(bus.addr[p] % MS);
            exp_rdata[p]  = ref_mem[idx];
            exp_rvalid[p] = 1'b1;
         end
      end
      for (int p = 0; p < PC; p++) begin
         if (exp_gnt[p] && bus.we[p]) begin
            idx = int'(bus.addr[p] % MS);
            n   = int'(bus.wsize[p]);
            if (n == 0 || n > BU) n = BU;
            for (int k = 0; k < n; k++) ref_mem[idx][k*US +: US] = bus.wdata[p][k*US +: US];
         end
      end
      for (int b = 0; b < NB; b++) begin
         if (win_m[b] >= 0) rr_m[b] = (win_m[b] + 1) % PC;
      end
   endtask

   // One bus cycle: grant check mid-cycle, response checks just after the edge.
   task automatic run_cycle(input int fixed_gnt);
      #2;
      model_arbitrate();
      checkOutput("gnt", BS'(bus.gnt), BS'(exp_gnt));
      if (fixed_gnt >= 0) checkOutput("gnt_directed", BS'(bus.gnt), BS'(fixed_gnt));
      @(posedge clk);
      model_clock();
      #1;
      checkOutput("rvalid", BS'(bus.rvalid), BS'(exp_rvalid));
      for (int p = 0; p < PC; p++) checkOutput($sformatf("rdata%0d", p), bus.rdata[p], exp_rdata[p]);
   endtask

   // Safety net so the run always terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence.
   initial begin
      logic [BS-1:0] d;
      logic [BS-1:0] a;
      for (int b = 0; b < NB; b++) rr_m[b] = 0;
      for (int p = 0; p < PC; p++) exp_rdata[p] = '0;
      exp_rvalid = '0;

      rst = 1'b1;
      for (int p = 0; p < PC; p++) applyStimulus(p, 1'b1, 1'b0, AS'(p), '0, 3'd0);
      #12;
      checkOutput("reset_gnt", BS'(bus.gnt), '0);
      checkOutput("reset_rvalid", BS'(bus.rvalid), '0);
      for (int p = 0; p < PC; p++) checkOutput($sformatf("reset_rdata%0d", p), bus.rdata[p], '0);
      idle_all();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] preloading rows 0..15");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 1'b1, 1'b1, AS'(i), rand_block(), 3'd0);
         run_cycle(1);
      end

      $display("[TB] write then read back on port 0");
      d = rand_block();
      applyStimulus(0, 1'b1, 1'b1, 24'h10, d, 3'd0);
      run_cycle(1);
      applyStimulus(0, 1'b1, 1'b0, 24'h10, '0, 3'd0);
      run_cycle(1);
      checkOutput("t1_rdata", bus.rdata[0], d);
      idle_all();
      run_cycle(0);

      $display("[TB] partial write of two units");
      applyStimulus(2, 1'b1, 1'b1, 24'h10, {BS{1'b1}}, 3'd0);
      run_cycle(4);
      applyStimulus(2, 1'b1, 1'b1, 24'h10, '0, 3'd2);
      run_cycle(4);
      applyStimulus(2, 1'b1, 1'b0, 24'h10, '0, 3'd0);
      run_cycle(4);
      checkOutput("t2_partial", bus.rdata[2], {{3{32'hFFFF_FFFF}}, 64'h0});
      idle_all();

      $display("[TB] reset right after a read grant");
      applyStimulus(0, 1'b1, 1'b0, 24'h2, '0, 3'd0);
      run_cycle(1);
      for (int p = 0; p < PC; p++) applyStimulus(p, 1'b1, 1'b0, AS'(2 * p), '0, 3'd0);
      rst = 1'b1;
      #1;
      checkOutput("midreset_rvalid", BS'(bus.rvalid), '0);
      checkOutput("midreset_gnt", BS'(bus.gnt), '0);
      for (int p = 0; p < PC; p++) checkOutput($sformatf("midreset_rdata%0d", p), bus.rdata[p], '0);
      exp_rvalid = '0;
      for (int p = 0; p < PC; p++) exp_rdata[p] = '0;
      for (int b = 0; b < NB; b++) rr_m[b] = 0;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) run_cycle(1 << (i % PC));
      idle_all();

      $display("[TB] parallel reads on two banks");
      applyStimulus(0, 1'b1, 1'b0, 24'h0, '0, 3'd0);
      applyStimulus(1, 1'b1, 1'b0, 24'h1, '0, 3'd0);
      run_cycle(3);
      idle_all();
      run_cycle(0);
      checkOutput("t4_rvalid_pulse", BS'(bus.rvalid), '0);

      $display("[TB] write and read colliding on one bank");
      a = rand_block();
      applyStimulus(1, 1'b1, 1'b1, 24'h4, a, 3'd0);
      applyStimulus(3, 1'b1, 1'b0, 24'h4, '0, 3'd0);
      run_cycle(2);
      applyStimulus(1, 1'b0, 1'b0, '0, '0, 3'd0);
      run_cycle(8);
      checkOutput("t5_raw_data", bus.rdata[3], a);
      idle_all();

      $display("[TB] random traffic");
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < PC; p++) begin
            if (!bus.req[p] || exp_gnt[p]) begin
               applyStimulus(p, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                             AS'((32'($urandom_range(0, 3)) << 10) | 32'($urandom_range(0, 15))),
                             rand_block(), 3'($urandom_range(0, 7)));
            end
         end
         run_cycle(-1);
      end
      idle_all();
      run_cycle(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
